// File: rtl/out_uart_reporter.sv
// Reports the SoC out word over an 8N1 UART line as eight uppercase hex digits plus CR LF.
// A frame launches whenever the word differs from the last one reported or a resend is requested.
module out_uart_reporter #(
    parameter int CLK_FREQ     = 6_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] value,
    input  logic        send,
    output logic        tx,
    output logic        busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("out_uart_reporter: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [31:0]      last_sent;
    logic [31:0]      shadow;
    logic [3:0]       char_idx;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] baud_cnt;
    logic             send_pend;

    logic [31:0] shifted;
    logic [3:0]  nibble;
    logic [7:0]  cur_char;
    logic [2:0]  next_bit;
    logic        launch;
    logic        bit_done;

    // Character currently on the wire: hex digits MSB nibble first, then CR and LF.
    always_comb begin
        shifted  = shadow << {char_idx[2:0], 2'b00};
        nibble   = shifted[31:28];
        next_bit = bit_idx + 3'd1;
        launch   = (value != last_sent) || send || send_pend;
        bit_done = (baud_cnt == CNT_MAX);
        if (char_idx == 4'd8) begin
            cur_char = 8'h0D;
        end else if (char_idx == 4'd9) begin
            cur_char = 8'h0A;
        end else if (nibble < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nibble};
        end else begin
            cur_char = 8'h37 + {4'h0, nibble};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            last_sent <= '0;
            shadow    <= '0;
            char_idx  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            send_pend <= 1'b0;
        end else begin
            if (state != IDLE && send) begin
                send_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    if (launch) begin
                        shadow    <= value;
                        last_sent <= value;
                        send_pend <= 1'b0;
                        char_idx  <= '0;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= cur_char[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= next_bit;
                            tx      <= cur_char[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (char_idx == 4'd9) begin
                            char_idx <= '0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            // Next character starts immediately, no idle gap inside a frame.
                            char_idx <= char_idx + 4'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/out_uart_reporter.md
# out_uart_reporter

Downstream consumer of the MIC-1 SoC `out` word on the iCEBreaker top level. The block watches the 32-bit output register and sends its value over UART (8N1) whenever it changes or a resend is requested. Each value goes out as eight uppercase ASCII hex characters followed by CR LF. It drives the board `TX` pin, which is currently tied high.

## Interface
- `CLK_FREQ`, default 6_000_000: clock frequency in Hz.
- `BAUD`, default 115200: serial bit rate.
- `CLKS_PER_BIT`, default `CLK_FREQ/BAUD` (integer division, 52 at defaults): cycles per serial bit. Must be ≥ 2; elaboration fails otherwise.

Ports:
- `clk`  in  1: clock.
- `resetn`  in  1: reset, synchronous, active-low.
- `value`  in  32: SoC `out` word, synchronous to `clk`.
- `send`  in  1: single-cycle request to retransmit the current `value` even if unchanged.
- `tx`  out  1: UART line, idle high.
- `busy`  out  1: high while a frame is in flight.

## Operation
- Registers:
  - `last_sent[31:0]`: value of the most recent frame.
  - `shadow[31:0]`: value currently being sent.
  - `char_idx` 0..9, `bit_idx` 0..7, `baud_cnt` 0..CLKS_PER_BIT-1.
  - `send_pend`: latched `send`.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: `tx`=1, `busy`=0. Launch when `value != last_sent` OR `send` OR `send_pend`.
  - On launch: `shadow <= value`, `last_sent <= value`, clear `send_pend`, `char_idx <= 0`, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA with `bit_idx`=0.
- DATA: `tx` = bit `bit_idx` of the current char, LSB first, CLKS_PER_BIT cycles per bit. Go to STOP after bit 7.
- STOP: `tx`=1 for CLKS_PER_BIT cycles.
  - If `char_idx` < 9: increment it and go to START. Characters are back-to-back with no extra idle.
  - If `char_idx` = 9: go to IDLE.
- Char mapping:
  - `char_idx` 0..7 take nibble `shadow[31-4k -: 4]`, MSB nibble first.
  - Nibble n < 10 maps to 0x30+n; otherwise 0x37+n (0x41..0x46).
  - `char_idx` 8 is 0x0D; `char_idx` 9 is 0x0A.
- `value` changes during a frame do not affect that frame, because `shadow` is frozen. When IDLE is re-entered, the latest `value` is compared with `last_sent`. Intermediate values may be skipped; the final value is always reported.
- `send` asserted while busy sets `send_pend`. Multiple requests collapse into a single resend.
- `send` asserted together with a value change in IDLE produces one frame.

## Timing
- Reset values: `tx`=1, `busy`=0, state IDLE, `last_sent`=0, `send_pend`=0, all counters 0. Consequently `value`=0 after reset sends nothing.
- Reset mid-frame: at the next edge with `resetn`=0, `tx`=1 and `busy`=0. The frame is abandoned and `last_sent` clears to 0.
- Launch latency: the condition is true in IDLE at cycle N; `tx` falls and `busy` rises at edge N+1.
- Frame length: `busy` is high for exactly 100·CLKS_PER_BIT cycles (10 chars × 10 bits). `tx` and `busy` are registered outputs.
- After `busy` falls, the block spends at least one IDLE cycle with `tx`=1 before the next start bit.
- Bit boundaries fall exactly every CLKS_PER_BIT cycles, measured from the `tx` falling edge. There is no cumulative drift.

## Test plan
- Set CLK_FREQ=8, BAUD=1 (CLKS_PER_BIT=8). After reset set `value`=0x12ABCD0F. Required: the UART monitor decodes 0x31 0x32 0x41 0x42 0x43 0x44 0x30 0x46 0x0D 0x0A; `busy` stays high for exactly 800 cycles; `tx` falls one cycle after `value` changes.
- Hold `value`=0 after reset for 2000 cycles → `tx` stays 1 and `busy` stays 0. Then pulse `send` → frame "00000000\r\n".
- Launch 0x00000001, change to 0x00000002 at cycle 100, then 0x00000003 at cycle 200 of the frame. Required: two frames, "00000001\r\n" then "00000003\r\n"; 0x00000002 is never sent.
- Pulse `send` three times during a frame with `value` unchanged. Required: exactly one retransmission of the same value after at least one idle cycle.
- Pull `resetn` low for one cycle in the middle of char 4. Required: `tx`=1 and `busy`=0 on the next edge. With `value` unchanged and nonzero, a fresh complete frame starts after release.
- Set `value`=0xFFFFFFFF, then 0x80000000. Required: characters 0x46×8, then 0x38 followed by 0x30×7, each frame terminated by 0x0D 0x0A.
